// File: rtl/tl_ul_pkg.sv
// -----------------------------------------------------------------------------
// tl_ul_pkg
// Shared TileLink-UL definitions for the 8-bit-source / 32-bit-address /
// 8-bit-sink / 32-bit-data bus flavour (TL_UL_8_32_8_32).
//   tl_a_op_e     : A-channel opcodes used by a UL initiator
//   tl_d_op_e     : D-channel response opcodes
//   TL_FULL_SIZE  : log2 of the full-word transfer size (4 bytes)
//   tl_put_opcode : picks PutFullData or PutPartialData from a byte mask
// -----------------------------------------------------------------------------
package tl_ul_pkg;

    typedef enum logic [2:0] {
        PutFullData    = 3'd0,
        PutPartialData = 3'd1,
        Get            = 3'd4
    } tl_a_op_e;

    typedef enum logic [2:0] {
        AccessAck     = 3'd0,
        AccessAckData = 3'd1
    } tl_d_op_e;

    localparam logic [1:0] TL_FULL_SIZE = 2'd2;

    localparam int TL_AW    = 32;
    localparam int TL_DW    = 32;
    localparam int TL_SRCW  = 8;
    localparam int TL_SINKW = 8;
    localparam int TL_MW    = TL_DW / 8;

    // Only an all-ones mask is a full-word put; every other mask, including
    // an empty one, has to go out as a partial put.
    function automatic logic [2:0] tl_put_opcode(input logic [TL_MW-1:0] mask);
        return (mask == {TL_MW{1'b1}}) ? PutFullData : PutPartialData;
    endfunction

endpackage

// File: rtl/tl_ul_if.sv
// -----------------------------------------------------------------------------
// TL_UL_8_32_8_32
// TileLink-UL bus bundle: 8-bit source, 32-bit address, 8-bit sink,
// 32-bit data (4 byte lanes).
//   producer  : initiator side (drives A channel and d_ready)
//   responder : target side (drives a_ready and the D channel)
// -----------------------------------------------------------------------------
interface TL_UL_8_32_8_32;
    import tl_ul_pkg::*;

    // A channel
    logic                 a_valid;
    logic                 a_ready;
    logic [2:0]           a_opcode;
    logic [2:0]           a_param;
    logic [1:0]           a_size;
    logic [TL_SRCW-1:0]   a_source;
    logic [TL_AW-1:0]     a_address;
    logic [TL_MW-1:0]     a_mask;
    logic [TL_DW-1:0]     a_data;

    // D channel
    logic                 d_valid;
    logic                 d_ready;
    logic [2:0]           d_opcode;
    logic [2:0]           d_param;
    logic [1:0]           d_size;
    logic [TL_SRCW-1:0]   d_source;
    logic [TL_SINKW-1:0]  d_sink;
    logic [TL_DW-1:0]     d_data;
    logic                 d_error;

    modport producer (
        output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
        input  a_ready,
        input  d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error,
        output d_ready
    );

    modport responder (
        input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data,
        output a_ready,
        output d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_data, d_error,
        input  d_ready
    );

endinterface

// File: rtl/tl_ul_host.sv
// -----------------------------------------------------------------------------
// tl_ul_host
// TileLink-UL initiator with a one-request-at-a-time command port. Each
// command becomes a single Get / PutFullData / PutPartialData on the A
// channel; the matching D beat is turned into a response. Only one
// transaction is ever outstanding. A WAIT-state timeout abandons a
// transaction whose target never answers.
//
// Parameters
//   TIMEOUT      WAIT cycles before abandoning a transaction (0 = never)
// Ports
//   clk          clock, rising edge
//   rst_b        asynchronous active-low reset
//   cmd_valid    command present
//   cmd_ready    command accepted (high only in IDLE)
//   cmd_write    1 = put, 0 = get
//   cmd_addr     byte address, bits [1:0] ignored
//   cmd_wdata    write data
//   cmd_mask     byte enables (puts only)
//   rsp_valid    response present (held until rsp_ready)
//   rsp_ready    response consumed
//   rsp_rdata    read data; 0 for puts, errors and timeouts
//   rsp_error    d_error, opcode mismatch or timeout
//   rsp_timeout  transaction abandoned
//   stray        one-cycle pulse after a dropped D beat
//   tl           TileLink-UL bus, producer side
// -----------------------------------------------------------------------------
module tl_ul_host
    import tl_ul_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst_b,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_write,
    input  logic [TL_AW-1:0]        cmd_addr,
    input  logic [TL_DW-1:0]        cmd_wdata,
    input  logic [TL_MW-1:0]        cmd_mask,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [TL_DW-1:0]        rsp_rdata,
    output logic                    rsp_error,
    output logic                    rsp_timeout,
    output logic                    stray,
    TL_UL_8_32_8_32.producer        tl
);

    localparam int TO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    // The counter starts at 0 in the first WAIT cycle, so the last cycle
    // before giving up is the one where it reads TIMEOUT-1.
    localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT > 0) ? TO_W'(TIMEOUT - 1) : '0;
    localparam bit TO_EN = (TIMEOUT > 0);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_RSP  = 2'd3;

    logic [1:0]          r_state;
    logic [TL_SRCW-1:0]  r_src_ctr;
    logic [TO_W-1:0]     r_to_ctr;
    logic                r_stray;

    logic [2:0]          r_a_opcode;
    logic [TL_AW-1:0]    r_a_address;
    logic [TL_DW-1:0]    r_a_data;
    logic [TL_SRCW-1:0]  r_a_source;
    logic [TL_MW-1:0]    r_a_mask;
    logic                r_is_get;

    logic [TL_DW-1:0]    r_rsp_rdata;
    logic                r_rsp_error;
    logic                r_rsp_timeout;

    logic                w_cmd_hs;
    logic                w_d_match;
    logic                w_to_hit;
    logic [2:0]          w_exp_op;
    logic                w_d_err;
    logic                w_unused_in;

    assign w_cmd_hs  = cmd_valid && (r_state == S_IDLE);
    // d_ready is tied high, so every d_valid cycle is an accepted beat.
    assign w_d_match = (r_state == S_WAIT) && tl.d_valid && (tl.d_source == r_a_source);
    assign w_to_hit  = TO_EN && (r_to_ctr == TO_LAST);
    assign w_exp_op  = r_is_get ? AccessAckData : AccessAck;
    assign w_d_err   = tl.d_error || (tl.d_opcode != w_exp_op);

    assign w_unused_in = ^{tl.d_param, tl.d_size, tl.d_sink, cmd_addr[1:0]};

    // Control: state, source counter, timeout counter, stray pulse.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_state   <= S_IDLE;
            r_src_ctr <= '0;
            r_to_ctr  <= '0;
            r_stray   <= 1'b0;
        end else begin
            r_stray <= tl.d_valid && !w_d_match;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid) begin
                        r_state <= S_REQ;
                    end
                end
                S_REQ: begin
                    if (tl.a_ready) begin
                        r_state   <= S_WAIT;
                        r_src_ctr <= r_src_ctr + 8'd1;
                        r_to_ctr  <= '0;
                    end
                end
                S_WAIT: begin
                    // A match takes priority over a timeout in the same cycle.
                    if (w_d_match || w_to_hit) begin
                        r_state <= S_RSP;
                    end else begin
                        r_to_ctr <= r_to_ctr + 1'b1;
                    end
                end
                S_RSP: begin
                    if (rsp_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Request capture and response capture.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            r_a_opcode    <= '0;
            r_a_address   <= '0;
            r_a_data      <= '0;
            r_a_source    <= '0;
            r_a_mask      <= '0;
            r_is_get      <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_error   <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            if (w_cmd_hs) begin
                r_a_address <= {cmd_addr[TL_AW-1:2], 2'b00};
                r_a_source  <= r_src_ctr;
                r_is_get    <= !cmd_write;
                if (cmd_write) begin
                    r_a_opcode <= tl_put_opcode(cmd_mask);
                    r_a_mask   <= cmd_mask;
                    r_a_data   <= cmd_wdata;
                end else begin
                    r_a_opcode <= Get;
                    r_a_mask   <= '1;
                    r_a_data   <= '0;
                end
            end
            if (w_d_match) begin
                r_rsp_error   <= w_d_err;
                r_rsp_timeout <= 1'b0;
                r_rsp_rdata   <= (r_is_get && !w_d_err) ? tl.d_data : '0;
            end else if ((r_state == S_WAIT) && w_to_hit) begin
                r_rsp_error   <= 1'b1;
                r_rsp_timeout <= 1'b1;
                r_rsp_rdata   <= '0;
            end
        end
    end

    assign cmd_ready    = (r_state == S_IDLE);
    assign rsp_valid    = (r_state == S_RSP);
    assign rsp_rdata    = r_rsp_rdata;
    assign rsp_error    = r_rsp_error;
    assign rsp_timeout  = r_rsp_timeout;
    assign stray        = r_stray;

    assign tl.a_valid   = (r_state == S_REQ);
    assign tl.a_opcode  = r_a_opcode;
    assign tl.a_param   = 3'd0;
    assign tl.a_size    = TL_FULL_SIZE;
    assign tl.a_source  = r_a_source;
    assign tl.a_address = r_a_address;
    assign tl.a_mask    = r_a_mask;
    assign tl.a_data    = r_a_data;
    assign tl.d_ready   = 1'b1;

endmodule

// File: tb/tb_tl_ul_host.sv
// -----------------------------------------------------------------------------
// tb_tl_ul_host
// Directed bench for tl_ul_host. Two instances share the stimulus: dut_a
// (TIMEOUT=4) and dut_b (TIMEOUT=2). 'sel' routes command valid and D beats
// to one of them and picks which outputs are observed.
// -----------------------------------------------------------------------------
module tb_tl_ul_host;
    import tl_ul_pkg::*;

    logic        clk = 1'b0;
    logic        rst_b = 1'b0;
    logic        sel = 1'b0;

    logic        cmd_valid = 1'b0;
    logic        cmd_write = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_mask = '0;
    logic        rsp_ready = 1'b0;

    logic        a_ready = 1'b1;
    logic        d_valid = 1'b0;
    logic [2:0]  d_opcode = '0;
    logic [7:0]  d_source = '0;
    logic [31:0] d_data = '0;
    logic        d_error = 1'b0;

    logic        cmd_ready_a, rsp_valid_a, rsp_error_a, rsp_timeout_a, stray_a;
    logic        cmd_ready_b, rsp_valid_b, rsp_error_b, rsp_timeout_b, stray_b;
    logic [31:0] rsp_rdata_a, rsp_rdata_b;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_src_a = 8'd0;

    always #5 clk = ~clk;

    TL_UL_8_32_8_32 tl_a ();
    TL_UL_8_32_8_32 tl_b ();

    assign tl_a.a_ready  = a_ready;
    assign tl_a.d_valid  = d_valid & ~sel;
    assign tl_a.d_opcode = d_opcode;
    assign tl_a.d_param  = 3'd0;
    assign tl_a.d_size   = 2'd2;
    assign tl_a.d_source = d_source;
    assign tl_a.d_sink   = 8'd0;
    assign tl_a.d_data   = d_data;
    assign tl_a.d_error  = d_error;

    assign tl_b.a_ready  = a_ready;
    assign tl_b.d_valid  = d_valid & sel;
    assign tl_b.d_opcode = d_opcode;
    assign tl_b.d_param  = 3'd0;
    assign tl_b.d_size   = 2'd2;
    assign tl_b.d_source = d_source;
    assign tl_b.d_sink   = 8'd0;
    assign tl_b.d_data   = d_data;
    assign tl_b.d_error  = d_error;

    tl_ul_host #(.TIMEOUT(4)) dut_a (
        .clk(clk), .rst_b(rst_b),
        .cmd_valid(cmd_valid & ~sel), .cmd_ready(cmd_ready_a), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_mask(cmd_mask),
        .rsp_valid(rsp_valid_a), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_a),
        .rsp_error(rsp_error_a), .rsp_timeout(rsp_timeout_a), .stray(stray_a),
        .tl(tl_a)
    );

    tl_ul_host #(.TIMEOUT(2)) dut_b (
        .clk(clk), .rst_b(rst_b),
        .cmd_valid(cmd_valid & sel), .cmd_ready(cmd_ready_b), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_mask(cmd_mask),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_b),
        .rsp_error(rsp_error_b), .rsp_timeout(rsp_timeout_b), .stray(stray_b),
        .tl(tl_b)
    );

    // Observed view of the selected instance.
    wire        m_cmd_ready   = sel ? cmd_ready_b   : cmd_ready_a;
    wire        m_rsp_valid   = sel ? rsp_valid_b   : rsp_valid_a;
    wire [31:0] m_rsp_rdata   = sel ? rsp_rdata_b   : rsp_rdata_a;
    wire        m_rsp_error   = sel ? rsp_error_b   : rsp_error_a;
    wire        m_rsp_timeout = sel ? rsp_timeout_b : rsp_timeout_a;
    wire        m_stray       = sel ? stray_b       : stray_a;
    wire        m_a_valid     = sel ? tl_b.a_valid   : tl_a.a_valid;
    wire [2:0]  m_a_opcode    = sel ? tl_b.a_opcode  : tl_a.a_opcode;
    wire [31:0] m_a_address   = sel ? tl_b.a_address : tl_a.a_address;
    wire [31:0] m_a_data      = sel ? tl_b.a_data    : tl_a.a_data;
    wire [7:0]  m_a_source    = sel ? tl_b.a_source  : tl_a.a_source;
    wire [1:0]  m_a_size      = sel ? tl_b.a_size    : tl_a.a_size;
    wire [3:0]  m_a_mask      = sel ? tl_b.a_mask    : tl_a.a_mask;
    wire        m_d_ready     = sel ? tl_b.d_ready   : tl_a.d_ready;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drives one transaction with a zero-wait responder and returns what was
    // seen at each fixed cycle: A fields in cycle 1, response in cycle 3,
    // cmd_ready in cycle 4.
    task automatic run_txn(
        input  logic        wr,
        input  logic [31:0] addr,
        input  logic [31:0] wdata,
        input  logic [3:0]  mask,
        input  logic [2:0]  dop,
        input  logic [31:0] ddata,
        input  logic        derr,
        output logic        av,
        output logic [2:0]  op,
        output logic [31:0] aaddr,
        output logic [31:0] adata,
        output logic [3:0]  amask,
        output logic [7:0]  asrc,
        output logic        rv,
        output logic [31:0] rdata,
        output logic        rerr,
        output logic        rto,
        output logic        st,
        output logic        cr
    );
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_mask = mask;
        step();
        cmd_valid = 1'b0;
        av = m_a_valid; op = m_a_opcode; aaddr = m_a_address; adata = m_a_data;
        amask = m_a_mask; asrc = m_a_source;
        step();
        d_valid = 1'b1; d_source = asrc; d_opcode = dop; d_data = ddata; d_error = derr;
        step();
        d_valid = 1'b0; d_error = 1'b0;
        rv = m_rsp_valid; rdata = m_rsp_rdata; rerr = m_rsp_error; rto = m_rsp_timeout; st = m_stray;
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        cr = m_cmd_ready;
    endtask

    task automatic test_reset();
        rst_b = 1'b0;
        step();
        step();
        n_cmp++;
        if ({m_cmd_ready, m_a_valid, m_d_ready, m_rsp_valid, m_rsp_error, m_rsp_timeout, m_stray} !== 7'b1010000) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b required 1010000",
                     {m_cmd_ready, m_a_valid, m_d_ready, m_rsp_valid, m_rsp_error, m_rsp_timeout, m_stray});
        end
        n_cmp++;
        if ({m_a_opcode, m_a_address, m_a_data, m_a_source, m_a_size, m_a_mask, m_rsp_rdata} !== {3'd0, 32'd0, 32'd0, 8'd0, 2'd2, 4'd0, 32'd0}) begin
            n_bad++;
            $display("FAIL reset_fields: got op=%0d addr=%h data=%h src=%0d size=%0d mask=%h rdata=%h required 0/0/0/0/2/0/0",
                     m_a_opcode, m_a_address, m_a_data, m_a_source, m_a_size, m_a_mask, m_rsp_rdata);
        end
        rst_b = 1'b1;
        step();
        n_cmp++;
        if (m_cmd_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_release_ready: got %b required 1", m_cmd_ready);
        end
    endtask

    task automatic test_get();
        logic av, rv, rerr, rto, st, cr;
        logic [2:0] op; logic [31:0] aaddr, adata, rdata; logic [3:0] amask; logic [7:0] asrc;
        run_txn(1'b0, 32'h1000_0007, 32'h5555_5555, 4'h0, AccessAckData, 32'hDEAD_BEEF, 1'b0,
                av, op, aaddr, adata, amask, asrc, rv, rdata, rerr, rto, st, cr);
        n_cmp++;
        if ({av, op, aaddr, amask, adata, asrc} !== {1'b1, 3'd4, 32'h1000_0004, 4'hF, 32'h0, exp_src_a}) begin
            n_bad++;
            $display("FAIL get_a: got v=%b op=%0d addr=%h mask=%h data=%h src=%0d required 1/4/10000004/f/0/%0d",
                     av, op, aaddr, amask, adata, asrc, exp_src_a);
        end
        n_cmp++;
        if ({rv, rdata, rerr, rto, st, cr} !== {1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 1'b1}) begin
            n_bad++;
            $display("FAIL get_rsp: got v=%b rdata=%h err=%b to=%b stray=%b cr=%b required 1/deadbeef/0/0/0/1",
                     rv, rdata, rerr, rto, st, cr);
        end
        exp_src_a++;
        // Opcode mismatch: a get answered with AccessAck is an error with no data.
        run_txn(1'b0, 32'h1000_0100, 32'h0, 4'h0, AccessAck, 32'h1234_5678, 1'b0,
                av, op, aaddr, adata, amask, asrc, rv, rdata, rerr, rto, st, cr);
        n_cmp++;
        if ({asrc, rv, rdata, rerr, rto} !== {exp_src_a, 1'b1, 32'h0, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL get_opcode_mismatch: got src=%0d v=%b rdata=%h err=%b to=%b required %0d/1/0/1/0",
                     asrc, rv, rdata, rerr, rto, exp_src_a);
        end
        exp_src_a++;
    endtask

    task automatic test_writes();
        logic av, rv, rerr, rto, st, cr;
        logic [2:0] op; logic [31:0] aaddr, adata, rdata; logic [3:0] amask; logic [7:0] asrc;
        logic [3:0]  masks  [3] = '{4'h3, 4'hF, 4'h0};
        logic [2:0]  ops    [3] = '{3'd1, 3'd0, 3'd1};
        for (int i = 0; i < 3; i++) begin
            run_txn(1'b1, 32'h2000_0012 + 32'(i * 16), 32'h1122_3340 + 32'(i), masks[i], AccessAck,
                    32'hAAAA_5555, 1'b0, av, op, aaddr, adata, amask, asrc, rv, rdata, rerr, rto, st, cr);
            n_cmp++;
            if ({av, op, aaddr, amask, adata, asrc} !==
                {1'b1, ops[i], 32'h2000_0010 + 32'(i * 16), masks[i], 32'h1122_3340 + 32'(i), exp_src_a}) begin
                n_bad++;
                $display("FAIL write_a[%0d]: got op=%0d addr=%h mask=%h data=%h src=%0d required op=%0d mask=%h src=%0d",
                         i, op, aaddr, amask, adata, asrc, ops[i], masks[i], exp_src_a);
            end
            n_cmp++;
            if ({rv, rdata, rerr, rto, cr} !== {1'b1, 32'h0, 1'b0, 1'b0, 1'b1}) begin
                n_bad++;
                $display("FAIL write_rsp[%0d]: got v=%b rdata=%h err=%b to=%b cr=%b required 1/0/0/0/1",
                         i, rv, rdata, rerr, rto, cr);
            end
            exp_src_a++;
        end
    endtask

    task automatic test_backpressure();
        sel = 1'b1;
        a_ready = 1'b0;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h3000_000B;
        cmd_wdata = 32'hCAFE_F00D; cmd_mask = 4'hC;
        step();
        cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            n_cmp++;
            if ({m_a_valid, m_a_opcode, m_a_address, m_a_mask, m_a_data, m_a_source, m_rsp_valid} !==
                {1'b1, 3'd1, 32'h3000_0008, 4'hC, 32'hCAFE_F00D, 8'd0, 1'b0}) begin
                n_bad++;
                $display("FAIL bp_hold[%0d]: got v=%b op=%0d addr=%h mask=%h data=%h src=%0d rspv=%b required 1/1/30000008/c/cafef00d/0/0",
                         i, m_a_valid, m_a_opcode, m_a_address, m_a_mask, m_a_data, m_a_source, m_rsp_valid);
            end
            step();
        end
        a_ready = 1'b1;
        step();
        d_valid = 1'b1; d_source = 8'd0; d_opcode = AccessAck; d_data = 32'h1234_5678; d_error = 1'b1;
        step();
        d_valid = 1'b0; d_error = 1'b0;
        n_cmp++;
        if ({m_rsp_valid, m_rsp_rdata, m_rsp_error, m_rsp_timeout} !== {1'b1, 32'h0, 1'b1, 1'b0}) begin
            n_bad++;
            $display("FAIL bp_d_error: got v=%b rdata=%h err=%b to=%b required 1/0/1/0",
                     m_rsp_valid, m_rsp_rdata, m_rsp_error, m_rsp_timeout);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        sel = 1'b0;
    endtask

    task automatic test_timeout();
        logic [7:0] src;
        logic       extra;
        src = exp_src_a;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h4000_0000; cmd_mask = 4'h0;
        step();
        cmd_valid = 1'b0;
        step();                 // A handshake happened at this edge (cycle 1)
        for (int i = 2; i < 6; i++) begin
            n_cmp++;
            if (m_rsp_valid !== 1'b0) begin
                n_bad++;
                $display("FAIL timeout_early[cycle %0d]: got rsp_valid=%b required 0", i, m_rsp_valid);
            end
            step();
        end
        n_cmp++;
        if ({m_rsp_valid, m_rsp_rdata, m_rsp_error, m_rsp_timeout} !== {1'b1, 32'h0, 1'b1, 1'b1}) begin
            n_bad++;
            $display("FAIL timeout_rsp: got v=%b rdata=%h err=%b to=%b required 1/0/1/1",
                     m_rsp_valid, m_rsp_rdata, m_rsp_error, m_rsp_timeout);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        exp_src_a++;
        // Late reply carrying the abandoned source.
        d_valid = 1'b1; d_source = src; d_opcode = AccessAckData; d_data = 32'h7777_7777;
        step();
        d_valid = 1'b0;
        n_cmp++;
        if (m_stray !== 1'b1) begin
            n_bad++;
            $display("FAIL late_stray: got %b required 1", m_stray);
        end
        extra = m_rsp_valid;
        step();
        n_cmp++;
        if (m_stray !== 1'b0) begin
            n_bad++;
            $display("FAIL stray_pulse_width: got %b required 0", m_stray);
        end
        for (int i = 0; i < 3; i++) begin
            extra = extra | m_rsp_valid;
            step();
        end
        n_cmp++;
        if ({extra, m_cmd_ready} !== 2'b01) begin
            n_bad++;
            $display("FAIL late_no_rsp: got rsp_seen=%b cmd_ready=%b required 0/1", extra, m_cmd_ready);
        end
    endtask

    task automatic test_back_to_back();
        logic av, rv, rerr, rto, st, cr;
        logic [2:0] op; logic [31:0] aaddr, adata, rdata; logic [3:0] amask; logic [7:0] asrc;
        int bad_src;
        int bad_rsp;
        bad_src = 0;
        bad_rsp = 0;
        for (int i = 0; i < 256; i++) begin
            run_txn(1'b0, 32'h6000_0000 + 32'(i * 4), 32'h0, 4'h0, AccessAckData,
                    32'hA500_0000 | 32'(i), 1'b0,
                    av, op, aaddr, adata, amask, asrc, rv, rdata, rerr, rto, st, cr);
            n_cmp++;
            if (asrc !== exp_src_a) begin
                n_bad++;
                $display("FAIL b2b_src[%0d]: got %0d required %0d", i, asrc, exp_src_a);
            end
            n_cmp++;
            if ({rv, rdata, rerr, cr} !== {1'b1, 32'hA500_0000 | 32'(i), 1'b0, 1'b1}) begin
                n_bad++;
                $display("FAIL b2b_rsp[%0d]: got v=%b rdata=%h err=%b cr=%b required 1/%h/0/1",
                         i, rv, rdata, rerr, cr, 32'hA500_0000 | 32'(i));
            end
            exp_src_a++;
        end
    endtask

    task automatic test_rsp_stall();
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h5000_0020;
        step();
        cmd_valid = 1'b0;
        step();
        d_valid = 1'b1; d_source = exp_src_a; d_opcode = AccessAckData; d_data = 32'h0BAD_CAFE;
        step();
        d_valid = 1'b0; d_data = 32'h0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++;
            if ({m_rsp_valid, m_rsp_rdata, m_rsp_error, m_rsp_timeout, m_cmd_ready} !==
                {1'b1, 32'h0BAD_CAFE, 1'b0, 1'b0, 1'b0}) begin
                n_bad++;
                $display("FAIL stall_hold[%0d]: got v=%b rdata=%h err=%b to=%b cr=%b required 1/0badcafe/0/0/0",
                         i, m_rsp_valid, m_rsp_rdata, m_rsp_error, m_rsp_timeout, m_cmd_ready);
            end
            if (i == 3) rsp_ready = 1'b1;
            step();
        end
        rsp_ready = 1'b0;
        n_cmp++;
        if ({m_rsp_valid, m_cmd_ready} !== 2'b01) begin
            n_bad++;
            $display("FAIL stall_release: got v=%b cr=%b required 0/1", m_rsp_valid, m_cmd_ready);
        end
        exp_src_a++;
    endtask

    task automatic test_reset_mid();
        logic av, rv, rerr, rto, st, cr;
        logic [2:0] op; logic [31:0] aaddr, adata, rdata; logic [3:0] amask; logic [7:0] asrc;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h7000_0004; cmd_wdata = 32'hFFFF_0000; cmd_mask = 4'hF;
        step();
        cmd_valid = 1'b0;
        step();                 // now in WAIT with a nonzero source issued
        rst_b = 1'b0;
        #1;
        n_cmp++;
        if ({m_cmd_ready, m_a_valid, m_d_ready, m_rsp_valid, m_rsp_error, m_rsp_timeout, m_stray} !== 7'b1010000) begin
            n_bad++;
            $display("FAIL midreset_ctrl: got %b required 1010000",
                     {m_cmd_ready, m_a_valid, m_d_ready, m_rsp_valid, m_rsp_error, m_rsp_timeout, m_stray});
        end
        n_cmp++;
        if ({m_a_opcode, m_a_address, m_a_data, m_a_source, m_a_size, m_a_mask, m_rsp_rdata} !== {3'd0, 32'd0, 32'd0, 8'd0, 2'd2, 4'd0, 32'd0}) begin
            n_bad++;
            $display("FAIL midreset_fields: got op=%0d addr=%h data=%h src=%0d size=%0d mask=%h rdata=%h required 0/0/0/0/2/0/0",
                     m_a_opcode, m_a_address, m_a_data, m_a_source, m_a_size, m_a_mask, m_rsp_rdata);
        end
        step();
        rst_b = 1'b1;
        step();
        exp_src_a = 8'd0;
        run_txn(1'b0, 32'h7000_0008, 32'h0, 4'h0, AccessAckData, 32'h0000_00C3, 1'b0,
                av, op, aaddr, adata, amask, asrc, rv, rdata, rerr, rto, st, cr);
        n_cmp++;
        if ({asrc, op, rv, rdata, rerr} !== {8'd0, 3'd4, 1'b1, 32'h0000_00C3, 1'b0}) begin
            n_bad++;
            $display("FAIL midreset_next: got src=%0d op=%0d v=%b rdata=%h err=%b required 0/4/1/000000c3/0",
                     asrc, op, rv, rdata, rerr);
        end
    endtask

    initial begin
        test_reset();
        test_get();
        test_writes();
        test_backpressure();
        test_timeout();
        test_back_to_back();
        test_rsp_stall();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
